// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_arb_pkg: shared FSM encoding, beat counter width and tag-width helper for fifo_rr_arbiter
package fifo_arb_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;
    localparam int BEAT_CNT_W = 16;
    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = 16'hFFFF;
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fifo_rr_arbiter_pick.sv
// rr_pick: combinational rotate-priority picker
// Ports: req (candidate vector), rr_ptr (highest-priority index) -> win (chosen index), found (any candidate)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_WIDTH = tag_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [TAG_WIDTH-1:0] rr_ptr,
    output logic [TAG_WIDTH-1:0] win,
    output logic                 found
);
    logic [TAG_WIDTH-1:0] j;
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = '0;
        // Farthest offset first so the nearest valid index overwrites it.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = TAG_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[j]) begin
                win   = j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin merge of NUM_REQ valid/ready producers onto one sync_fifo write port
// Ports: clk, rst_n (async, active-low); req_valid/req_ready/req_data per requester;
//        fifo_ivalid/fifo_idata ({tag, payload}, registered) with fifo_iready; beat_cnt (saturating); busy.
// Optional: define FIFO_ARB_BURST_EN to lock a grant for up to BURST_LEN beats.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = tag_w(NUM_REQ),
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic                            fifo_ivalid,
    input  logic                            fifo_iready,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_idata,
    output logic [BEAT_CNT_W-1:0]           beat_cnt,
    output logic                            busy
);
    localparam int BW = $clog2(BURST_LEN + 1);

    state_e                          state_q, state_d;
    logic [BW-1:0]                   burst_q, burst_d;
    logic [TAG_WIDTH-1:0]            rr_ptr_q, rr_ptr_d;
    logic                            ivalid_q, ivalid_d;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] idata_q, idata_d;
    logic [BEAT_CNT_W-1:0]           cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]            win;
    logic [NUM_REQ-1:0]              cand;
    logic                            found, xfer;

    function automatic logic [TAG_WIDTH-1:0] nxt(input logic [TAG_WIDTH-1:0] i);
        return (i == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : i + TAG_WIDTH'(1);
    endfunction

`ifdef FIFO_ARB_BURST_EN
    logic [TAG_WIDTH-1:0] owner_q, owner_d;
    // While locked only the owner may win.
    assign cand = (state_q == LOCK) ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
`else
    assign cand = req_valid;
`endif

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .TAG_WIDTH(TAG_WIDTH)
    ) u_pick (
        .req   (cand),
        .rr_ptr(rr_ptr_q),
        .win   (win),
        .found (found)
    );

    assign xfer        = fifo_iready & found;
    assign req_ready   = (xfer & rst_n) ? (NUM_REQ'(1) << win) : '0;
    assign fifo_ivalid = ivalid_q;
    assign fifo_idata  = idata_q;
    assign beat_cnt    = cnt_q;
    assign busy        = (|req_valid) | ivalid_q;

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        rr_ptr_d = rr_ptr_q;
        ivalid_d = xfer;
        idata_d  = xfer ? {win, req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH]} : idata_q;
        cnt_d    = (xfer && cnt_q != BEAT_CNT_MAX) ? cnt_q + BEAT_CNT_W'(1) : cnt_q;
`ifdef FIFO_ARB_BURST_EN
        owner_d  = owner_q;
        if (state_q == IDLE) begin
            if (xfer) begin
                rr_ptr_d = nxt(win);
                if (BURST_LEN > 1) begin
                    state_d = LOCK;
                    owner_d = win;
                    burst_d = BW'(1);
                end
            end
        end else if (fifo_iready && !req_valid[owner_q]) begin
            // Owner went quiet while the FIFO could accept: release the lock.
            state_d  = IDLE;
            burst_d  = '0;
            rr_ptr_d = nxt(owner_q);
        end else if (xfer) begin
            burst_d = burst_q + BW'(1);
            if (burst_d == BW'(BURST_LEN)) begin
                state_d  = IDLE;
                burst_d  = '0;
                rr_ptr_d = nxt(owner_q);
            end
        end
`else
        if (xfer) rr_ptr_d = nxt(win);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            rr_ptr_q <= '0;
            ivalid_q <= 1'b0;
            idata_q  <= '0;
            cnt_q    <= '0;
`ifdef FIFO_ARB_BURST_EN
            owner_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            rr_ptr_q <= rr_ptr_d;
            ivalid_q <= ivalid_d;
            idata_q  <= idata_d;
            cnt_q    <= cnt_d;
`ifdef FIFO_ARB_BURST_EN
            owner_q  <= owner_d;
`endif
        end
    end
endmodule
